// File: rtl/ysyx_23060025_lsu_ms.sv
// ysyx_23060025_lsu_ms: memory-access stage between EXU and WBU issuing AXI4-Lite-style loads/stores
// Optional: define LSU_MISALIGN_CHECK_EN to trap misaligned halfword/word accesses instead of issuing them.
module ysyx_23060025_lsu_ms #(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                es_to_ms_valid,
    output logic                ms_allowin_o,
    input  logic                ws_allowin_i,
    output logic                ms_to_ws_valid_o,
    input  logic                mem_en_i,
    input  logic [3:0]          mem_type_i,
    input  logic [ADDR_LEN-1:0] addr_i,
    input  logic [DATA_LEN-1:0] store_data_i,
    input  logic                wd_i,
    input  logic [4:0]          wreg_i,
    input  logic [31:0]         csr_wdata_i,
    input  logic [2:0]          csr_type_i,
    input  logic [11:0]         csr_waddr_i,
    input  logic [31:0]         csr_mcause_i,
    input  logic                ebreak_flag_i,
    output logic                wd_o,
    output logic [4:0]          wreg_o,
    output logic [DATA_LEN-1:0] reg_wdata_o,
    output logic [31:0]         csr_wdata_o,
    output logic [2:0]          csr_type_o,
    output logic [11:0]         csr_waddr_o,
    output logic [31:0]         csr_mcause_o,
    output logic                ebreak_flag_o,
    output logic [31:0]         araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic [31:0]         awaddr,
    output logic                awvalid,
    output logic [31:0]         wdata,
    output logic [3:0]          wstrb,
    output logic                wvalid,
    input  logic                awready,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;
    state_t state, state_n, first_state;
    logic ms_valid, ms_ready_go, capture, aw_done, w_done, mis;
    logic [3:0] mem_type;
    logic [ADDR_LEN-1:0] addr;
    logic [DATA_LEN-1:0] sd, load_val;
    logic [31:0] sh, lane_data;
    logic [3:0] lane_strb;
    logic unused;

    assign unused = ^{rresp, bresp};
`ifdef LSU_MISALIGN_CHECK_EN
    assign mis = mem_en_i & ((mem_type_i[1:0] == 2'b01 & addr_i[0]) | (mem_type_i[1] & addr_i[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif
    assign ms_ready_go      = state == DONE;
    assign ms_allowin_o     = !ms_valid | (ms_ready_go & ws_allowin_i);
    assign ms_to_ws_valid_o = ms_valid & ms_ready_go;
    assign capture          = es_to_ms_valid & ms_allowin_o;
    assign first_state      = (!mem_en_i | mis) ? DONE : mem_type_i[3] ? WR_REQ : RD_ADDR;

    assign sh       = rdata >> {addr[1:0], 3'b000};
    assign load_val = mem_type[1:0] == 2'b00 ? {{(DATA_LEN-8){~mem_type[2] & sh[7]}}, sh[7:0]} :
                      mem_type[1:0] == 2'b01 ? {{(DATA_LEN-16){~mem_type[2] & sh[15]}}, sh[15:0]} : sh;
    assign lane_strb = mem_type[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
                       mem_type[1:0] == 2'b01 ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
    assign lane_data = mem_type[1:0] == 2'b00 ? {4{sd[7:0]}} :
                       mem_type[1:0] == 2'b01 ? {2{sd[15:0]}} : sd;

    assign arvalid = state == RD_ADDR;
    assign rready  = state == RD_DATA;
    assign bready  = state == WR_RESP;
    assign awvalid = state == WR_REQ & !aw_done;
    assign wvalid  = state == WR_REQ & !w_done;
    assign araddr  = {addr[31:2], 2'b00};
    assign awaddr  = {addr[31:2], 2'b00};
    assign wstrb   = wvalid ? lane_strb : 4'b0000;
    assign wdata   = wvalid ? lane_data : 32'h0;

    // State register
    always_ff @(posedge clock) begin
        state <= reset ? IDLE : state_n;
    end

    // Next-state: a capture in IDLE or DONE jumps straight to the new instruction's first state
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = capture ? first_state : IDLE;
            RD_ADDR: state_n = arready ? RD_DATA : RD_ADDR;
            RD_DATA: state_n = rvalid ? DONE : RD_DATA;
            WR_REQ:  state_n = ((aw_done | awready) & (w_done | wready)) ? WR_RESP : WR_REQ;
            WR_RESP: state_n = bvalid ? DONE : WR_RESP;
            DONE:    state_n = capture ? first_state : ws_allowin_i ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    // Per-channel write handshake tracking, cleared whenever WR_REQ is left
    always_ff @(posedge clock) begin
        if (reset || state_n != WR_REQ) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (awvalid & awready) aw_done <= 1'b1;
            if (wvalid & wready) w_done <= 1'b1;
        end
    end

    // Stage register: capture instruction fields, then fill in load data on read return
    always_ff @(posedge clock) begin
        if (reset) begin
            ms_valid      <= 1'b0;
            mem_type      <= '0;
            addr          <= '0;
            sd            <= '0;
            wd_o          <= 1'b0;
            wreg_o        <= '0;
            reg_wdata_o   <= '0;
            csr_wdata_o   <= '0;
            csr_type_o    <= '0;
            csr_waddr_o   <= '0;
            csr_mcause_o  <= '0;
            ebreak_flag_o <= 1'b0;
        end else if (capture) begin
            ms_valid      <= 1'b1;
            mem_type      <= mem_type_i;
            addr          <= addr_i;
            sd            <= store_data_i;
            wd_o          <= wd_i & ~(mem_en_i & mem_type_i[3]) & ~mis;
            wreg_o        <= wreg_i;
            reg_wdata_o   <= addr_i;
            csr_wdata_o   <= mis ? addr_i : csr_wdata_i;
            csr_type_o    <= mis ? 3'b100 : csr_type_i;
            csr_waddr_o   <= csr_waddr_i;
            csr_mcause_o  <= mis ? (mem_type_i[3] ? 32'd6 : 32'd4) : csr_mcause_i;
            ebreak_flag_o <= ebreak_flag_i;
        end else begin
            if (ms_to_ws_valid_o & ws_allowin_i) ms_valid <= 1'b0;
            if (state == RD_DATA & rvalid) reg_wdata_o <= load_val;
        end
    end
endmodule

// File: tb/tb_ysyx_23060025_lsu_ms.sv
// tb_ysyx_23060025_lsu_ms: directed checks of the LSU memory stage
module tb_ysyx_23060025_lsu_ms;
  logic clock = 0, reset;
  logic es_to_ms_valid, ms_allowin_o, ws_allowin_i, ms_to_ws_valid_o, mem_en_i;
  logic [3:0] mem_type_i;
  logic [31:0] addr_i, store_data_i, csr_wdata_i, csr_mcause_i;
  logic wd_i, ebreak_flag_i;
  logic [4:0] wreg_i;
  logic [2:0] csr_type_i;
  logic [11:0] csr_waddr_i;
  logic wd_o, ebreak_flag_o;
  logic [4:0] wreg_o;
  logic [31:0] reg_wdata_o, csr_wdata_o, csr_mcause_o;
  logic [2:0] csr_type_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic arvalid, arready, rvalid, rready, awvalid, wvalid, awready, wready, bvalid, bready;
  logic [1:0] rresp, bresp;
  logic [3:0] wstrb;
  int n_cmp = 0, n_err = 0;
  always #5 clock = ~clock;
  ysyx_23060025_lsu_ms dut (
    .clock(clock), .reset(reset), .es_to_ms_valid(es_to_ms_valid), .ms_allowin_o(ms_allowin_o),
    .ws_allowin_i(ws_allowin_i), .ms_to_ws_valid_o(ms_to_ws_valid_o), .mem_en_i(mem_en_i),
    .mem_type_i(mem_type_i), .addr_i(addr_i), .store_data_i(store_data_i), .wd_i(wd_i),
    .wreg_i(wreg_i), .csr_wdata_i(csr_wdata_i), .csr_type_i(csr_type_i), .csr_waddr_i(csr_waddr_i),
    .csr_mcause_i(csr_mcause_i), .ebreak_flag_i(ebreak_flag_i), .wd_o(wd_o), .wreg_o(wreg_o),
    .reg_wdata_o(reg_wdata_o), .csr_wdata_o(csr_wdata_o), .csr_type_o(csr_type_o),
    .csr_waddr_o(csr_waddr_o), .csr_mcause_o(csr_mcause_o), .ebreak_flag_o(ebreak_flag_o),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
    .rvalid(rvalid), .rready(rready), .awaddr(awaddr), .awvalid(awvalid), .wdata(wdata),
    .wstrb(wstrb), .wvalid(wvalid), .awready(awready), .wready(wready), .bresp(bresp),
    .bvalid(bvalid), .bready(bready)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic issue(input logic men, input logic [3:0] t, input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    es_to_ms_valid = 1; mem_en_i = men; mem_type_i = t; addr_i = a; store_data_i = d; wd_i = 1; wreg_i = r;
    tick();
    es_to_ms_valid = 0;
  endtask
  task automatic do_load(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d);
    issue(1, t, a, 32'h0, 5'd3);
    tick();
    arready = 1; tick(); arready = 0;
    tick();
    rdata = d; rvalid = 1; tick(); rvalid = 0;
  endtask
  initial begin
    reset = 1; es_to_ms_valid = 0; ws_allowin_i = 1; mem_en_i = 0; mem_type_i = 0; addr_i = 0;
    store_data_i = 0; wd_i = 0; wreg_i = 0; csr_wdata_i = 0; csr_type_i = 0; csr_waddr_i = 0;
    csr_mcause_i = 0; ebreak_flag_i = 0; arready = 0; rdata = 0; rresp = 0; rvalid = 0;
    awready = 0; wready = 0; bresp = 0; bvalid = 0;
    tick(); tick();
    chk("rst_allowin", ms_allowin_o, 1'b1);
    chk("rst_valid", ms_to_ws_valid_o, 1'b0);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wstrb", wstrb, 4'b0000);
    chk("rst_regw", reg_wdata_o, 32'h0);
    reset = 0;
    issue(0, 4'b0000, 32'h1234, 32'h0, 5'd5);
    chk("pt_valid", ms_to_ws_valid_o, 1'b1);
    chk("pt_regw", reg_wdata_o, 32'h1234);
    chk("pt_wreg", wreg_o, 5'd5);
    chk("pt_wd", wd_o, 1'b1);
    chk("pt_nobus", {arvalid, awvalid, wvalid}, 3'b000);
    tick();
    chk("pt_done", ms_to_ws_valid_o, 1'b0);
    issue(1, 4'b0000, 32'h8000_0003, 32'h0, 5'd3);
    chk("lb_arvalid", arvalid, 1'b1);
    chk("lb_araddr", araddr, 32'h8000_0000);
    chk("lb_novalid", ms_to_ws_valid_o, 1'b0);
    tick();
    arready = 1; tick(); arready = 0;
    chk("lb_ar_drop", arvalid, 1'b0);
    chk("lb_rready", rready, 1'b1);
    tick();
    rdata = 32'h80FF_FFFF; rvalid = 1; tick(); rvalid = 0;
    chk("lb_valid", ms_to_ws_valid_o, 1'b1);
    chk("lb_data", reg_wdata_o, 32'hFFFF_FF80);
    chk("lb_wd", wd_o, 1'b1);
    tick();
    do_load(4'b0100, 32'h8000_0003, 32'h80FF_FFFF);
    chk("lbu_data", reg_wdata_o, 32'h0000_0080);
    tick();
    do_load(4'b0001, 32'h8000_0002, 32'h8001_0000);
    chk("lh_data", reg_wdata_o, 32'hFFFF_8001);
    tick();
    issue(1, 4'b1001, 32'h8000_0002, 32'hABCD_1234, 5'd9);
    wready = 1;
    chk("sh_awvalid", awvalid, 1'b1);
    chk("sh_wvalid", wvalid, 1'b1);
    chk("sh_wstrb", wstrb, 4'b1100);
    chk("sh_wdata", wdata, 32'h1234_1234);
    chk("sh_awaddr", awaddr, 32'h8000_0000);
    tick(); wready = 0;
    chk("sh_w_drop", wvalid, 1'b0);
    chk("sh_aw_hold", awvalid, 1'b1);
    tick(); tick();
    chk("sh_aw_hold2", awvalid, 1'b1);
    awready = 1; tick(); awready = 0;
    chk("sh_aw_drop", awvalid, 1'b0);
    chk("sh_bready", bready, 1'b1);
    chk("sh_wait_b", ms_to_ws_valid_o, 1'b0);
    tick();
    chk("sh_wait_b2", ms_to_ws_valid_o, 1'b0);
    bvalid = 1; ws_allowin_i = 0; tick(); bvalid = 0;
    chk("sh_valid", ms_to_ws_valid_o, 1'b1);
    chk("sh_wd", wd_o, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_allowin", ms_allowin_o, 1'b0);
      chk("bp_valid", ms_to_ws_valid_o, 1'b1);
      chk("bp_wreg", wreg_o, 5'd9);
      tick();
    end
    ws_allowin_i = 1; es_to_ms_valid = 1; mem_en_i = 0; addr_i = 32'h5555; wreg_i = 5'd7; wd_i = 1;
    #1;
    chk("b2b_allowin", ms_allowin_o, 1'b1);
    tick(); es_to_ms_valid = 0;
    chk("b2b_valid", ms_to_ws_valid_o, 1'b1);
    chk("b2b_regw", reg_wdata_o, 32'h5555);
    chk("b2b_wreg", wreg_o, 5'd7);
    tick();
    chk("b2b_done", ms_to_ws_valid_o, 1'b0);
    issue(1, 4'b0010, 32'h8000_0000, 32'h0, 5'd1);
    arready = 1; tick(); arready = 0;
    chk("rr_rready", rready, 1'b1);
    reset = 1; tick(); reset = 0;
    chk("rr_arvalid", arvalid, 1'b0);
    chk("rr_rready0", rready, 1'b0);
    chk("rr_valid", ms_to_ws_valid_o, 1'b0);
    chk("rr_allowin", ms_allowin_o, 1'b1);
    tick();
    chk("rr_still_idle", ms_to_ws_valid_o, 1'b0);
`ifdef LSU_MISALIGN_CHECK_EN
    issue(1, 4'b0010, 32'h8000_0002, 32'h0, 5'd4);
    chk("mis_arvalid", arvalid, 1'b0);
    chk("mis_valid", ms_to_ws_valid_o, 1'b1);
    chk("mis_mcause", csr_mcause_o, 32'd4);
    chk("mis_type", csr_type_o, 3'b100);
    chk("mis_wdata", csr_wdata_o, 32'h8000_0002);
    chk("mis_wd", wd_o, 1'b0);
    tick();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ysyx_23060025_lsu_ms.md
Name: ysyx_23060025_lsu_ms

Overview:
Memory-access pipeline stage that sits between EXU and WBU, and drives the ms_to_ws_valid / ws_allowin handshake consumed by the writeback stage. It captures one instruction from EXU and issues loads and stores on an AXI4-Lite-style data bus. Load data is aligned and sign/zero-extended before the result, register/CSR write fields and ebreak flag are presented to WBU. Non-memory instructions pass through with one cycle of latency.

Parameters:
DATA_LEN, 32, data/register width
ADDR_LEN, 32, bus address width

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
es_to_ms_valid  in  1  EXU holds a valid instruction
ms_allowin_o  out  1  stage can accept from EXU this cycle
ws_allowin_i  in  1  WBU can accept
ms_to_ws_valid_o  out  1  result valid toward WBU
mem_en_i  in  1  instruction accesses memory
mem_type_i  in  4  [3]=store, [2]=unsigned load, [1:0]=size (00 B, 01 H, 10 W, 11 reserved→W)
addr_i  in  ADDR_LEN  effective address / ALU result
store_data_i  in  DATA_LEN  rs2 value
wd_i, wreg_i[4:0], csr_wdata_i[31:0], csr_type_i[2:0], csr_waddr_i[11:0], csr_mcause_i[31:0], ebreak_flag_i  in  pass-through fields
wd_o, wreg_o, reg_wdata_o, csr_wdata_o, csr_type_o, csr_waddr_o, csr_mcause_o, ebreak_flag_o  out  same widths, toward WBU
araddr[31:0], arvalid out; arready in; rdata[31:0], rresp[1:0], rvalid in; rready out
awaddr[31:0], awvalid, wdata[31:0], wstrb[3:0], wvalid out; awready, wready in; bresp[1:0], bvalid in; bready out

Behaviour:
- Stage register: ms_valid. ms_allowin_o = !ms_valid | (ms_ready_go & ws_allowin_i). When es_to_ms_valid & ms_allowin_o, all inputs are latched at the edge and ms_valid is set. Otherwise, if ms_to_ws_valid_o & ws_allowin_i, ms_valid is cleared.
- ms_to_ws_valid_o = ms_valid & ms_ready_go. All *_o fields come from latched registers and are held stable while ms_to_ws_valid_o=1 and ws_allowin_i=0.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- From IDLE, the FSM transitions on the capture edge:
  - load → RD_ADDR
  - store → WR_REQ
  - non-mem → DONE
- RD_ADDR: arvalid=1 and araddr = {addr[31:2],2'b00}. On arready, go to RD_DATA.
- RD_DATA: rready=1. On rvalid, latch the extracted load value and go to DONE.
- WR_REQ: awvalid and wvalid are asserted independently. Each drops after its own handshake, tracked with aw_done/w_done flags. When both are done, go to WR_RESP.
- WR_RESP: bready=1. On bvalid, go to DONE.
- ms_ready_go = (state==DONE). In DONE, on handoff the FSM returns to IDLE, or, if a new capture happens the same edge, goes directly to the new instruction's first state (back-to-back, no bubble).
- Load extraction: sh = rdata >> (8*addr[1:0]). Result is sign- or zero-extended from bit 7 (B) or bit 15 (H); W passes unchanged. Stores force wd_o=0.
- Store lanes:
  - B: wstrb = 4'b0001 << addr[1:0], wdata = {4{sd[7:0]}}
  - H: wstrb = 4'b0011 << {addr[1],1'b0}, wdata = {2{sd[15:0]}}
  - W: wstrb = 4'b1111
- Non-zero rresp/bresp is ignored (data is taken as-is).
- Reset values:
  - every output 0
  - state=IDLE, ms_valid=0, aw_done=w_done=0
  - ms_allowin_o=1 after reset
- Reset mid-transaction drops the instruction and all bus valids the next cycle. No result is emitted.
- Bus valids never deassert before their handshake completes.

Optional Feature:
LSU_MISALIGN_CHECK_EN:
- Defined: a halfword with addr[0]=1 or a word with addr[1:0]≠0 issues no bus transaction and goes straight to DONE. Outputs are forced to wd_o=0, csr_type_o=3'b100 (trap), csr_mcause_o=4 (load) or 6 (store), and csr_wdata_o=addr.
- Undefined: the address is word-aligned and the access is performed with the lane rules above. No trap is raised.

Test Plan:
- Non-mem passthrough: wd=1, wreg=5, addr_i=0x1234, ws_allowin=1 → ms_to_ws_valid_o exactly one cycle after capture, reg_wdata_o=0x1234, wreg_o=5, no bus activity.
- LB signed: addr=0x8000_0003, rdata=0x80FF_FFFF, arready/rvalid one-cycle delays → araddr=0x8000_0000, reg_wdata_o=0xFFFF_FF80. Repeated with LBU → 0x0000_0080.
- SH: addr=0x8000_0002, rs2=0xABCD_1234, awready delayed 3 cycles, wready immediate → wstrb=4'b1100, wdata=0x1234_1234, wvalid drops after 1 cycle, result only after bvalid, wd_o=0.
- Backpressure: ws_allowin_i=0 for 4 cycles with result ready → outputs stable, ms_allowin_o=0. When ws_allowin_i rises with es_to_ms_valid=1, a new instruction is captured on the same edge.
- Reset in RD_DATA: reset asserted before rvalid → arvalid/rready=0, ms_to_ws_valid_o=0 next cycle, state IDLE.
- With LSU_MISALIGN_CHECK_EN: LW at 0x8000_0002 → no arvalid, csr_mcause_o=4, csr_type_o=3'b100, csr_wdata_o=0x8000_0002.
